// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename lock.
// Reads return committed data or the ROB tag that will produce it.
module reg_file_rename #(
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [REG_W-1:0]  rd_addr1,
    output logic [DATA_W-1:0] rd_value1,
    output logic              rd_busy1,
    output logic [TAG_W-1:0]  rd_tag1,
    input  logic [REG_W-1:0]  rd_addr2,
    output logic [DATA_W-1:0] rd_value2,
    output logic              rd_busy2,
    output logic [TAG_W-1:0]  rd_tag2,
    input  logic              lock_en,
    input  logic [REG_W-1:0]  lock_reg,
    input  logic [TAG_W-1:0]  lock_tag,
    input  logic              commit_en,
    input  logic [REG_W-1:0]  commit_reg,
    input  logic [DATA_W-1:0] commit_data,
    input  logic [TAG_W-1:0]  commit_tag
);

    logic [DATA_W-1:0] data_q [REG_NUM];
    logic [TAG_W-1:0]  tag_q  [REG_NUM];
    logic [REG_NUM-1:0] busy_q;

    logic commit_ok;
    logic lock_ok;

    assign commit_ok = commit_en && (commit_reg != '0);
    assign lock_ok   = lock_en && (lock_reg != '0) && !flush;

    // Commit results are bypassed so the decoder never misses a retiring value.
    always_comb begin
        rd_value1 = '0;
        rd_busy1  = 1'b0;
        rd_tag1   = '0;
        if (rd_addr1 != '0) begin
            rd_value1 = data_q[rd_addr1];
            rd_busy1  = busy_q[rd_addr1];
            rd_tag1   = tag_q[rd_addr1];
            if (commit_en && (commit_reg == rd_addr1)) begin
                rd_value1 = commit_data;
                if (tag_q[rd_addr1] == commit_tag) begin
                    rd_busy1 = 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_value2 = '0;
        rd_busy2  = 1'b0;
        rd_tag2   = '0;
        if (rd_addr2 != '0) begin
            rd_value2 = data_q[rd_addr2];
            rd_busy2  = busy_q[rd_addr2];
            rd_tag2   = tag_q[rd_addr2];
            if (commit_en && (commit_reg == rd_addr2)) begin
                rd_value2 = commit_data;
                if (tag_q[rd_addr2] == commit_tag) begin
                    rd_busy2 = 1'b0;
                end
            end
        end
    end

    // Lock is applied after commit so a same-register rename keeps its lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q <= '0;
        end else begin
            if (commit_ok) begin
                data_q[commit_reg] <= commit_data;
                if (busy_q[commit_reg] && (tag_q[commit_reg] == commit_tag)) begin
                    busy_q[commit_reg] <= 1'b0;
                end
            end
            if (lock_ok) begin
                busy_q[lock_reg] <= 1'b1;
                tag_q[lock_reg]  <= lock_tag;
            end
            if (flush) begin
                busy_q <= '0;
            end
        end
    end

endmodule
